// File: rtl/pq_request_ctl.sv
// Request controller for the priority-queue demo: turns button pulses into
// insert/remove handshakes, captures removed entries and flags illegal ops.
module pq_request_ctl #(
    parameter int KW         = 4,
    parameter int VW         = 4,
    parameter int ERR_CYCLES = 50_000_000
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          btn_add,
    input  logic          btn_remove,
    input  logic [KW-1:0] sw_key,
    input  logic [VW-1:0] sw_val,
    input  logic          pq_full,
    input  logic          pq_empty,
    output logic          req_valid,
    output logic          req_op,
    output logic [KW-1:0] req_key,
    output logic [VW-1:0] req_val,
    input  logic          req_ready,
    input  logic          rsp_valid,
    input  logic [KW-1:0] rsp_key,
    input  logic [VW-1:0] rsp_val,
    output logic [KW-1:0] disp_key,
    output logic [VW-1:0] disp_val,
    output logic          disp_valid,
    output logic          err,
    output logic          busy,
    output logic [7:0]    op_count
);

    localparam int CW = (ERR_CYCLES > 1) ? $clog2(ERR_CYCLES) : 1;
    localparam logic [CW-1:0] ERR_LOAD = CW'(ERR_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2,
        S_ERR  = 2'd3
    } state_t;

    state_t        r_state;
    logic [CW-1:0] r_err_cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= S_IDLE;
            r_err_cnt  <= '0;
            req_valid  <= 1'b0;
            req_op     <= 1'b0;
            req_key    <= '0;
            req_val    <= '0;
            disp_key   <= '0;
            disp_val   <= '0;
            disp_valid <= 1'b0;
            err        <= 1'b0;
            busy       <= 1'b0;
            op_count   <= 8'd0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    // Remove takes priority; a simultaneous add pulse is dropped.
                    if ((btn_remove && pq_empty) || (!btn_remove && btn_add && pq_full)) begin
                        r_state   <= S_ERR;
                        r_err_cnt <= ERR_LOAD;
                        err       <= 1'b1;
                        busy      <= 1'b1;
                    end else if (btn_remove) begin
                        r_state   <= S_REQ;
                        req_valid <= 1'b1;
                        req_op    <= 1'b1;
                        req_key   <= '0;
                        req_val   <= '0;
                        busy      <= 1'b1;
                    end else if (btn_add) begin
                        r_state   <= S_REQ;
                        req_valid <= 1'b1;
                        req_op    <= 1'b0;
                        req_key   <= sw_key;
                        req_val   <= sw_val;
                        busy      <= 1'b1;
                    end
                end
                S_REQ: begin
                    if (req_ready) begin
                        req_valid <= 1'b0;
                        if (req_op) begin
                            r_state <= S_WAIT;
                        end else begin
                            r_state  <= S_IDLE;
                            busy     <= 1'b0;
                            op_count <= op_count + 8'd1;
                        end
                    end
                end
                S_WAIT: begin
                    if (rsp_valid) begin
                        r_state    <= S_IDLE;
                        disp_key   <= rsp_key;
                        disp_val   <= rsp_val;
                        disp_valid <= 1'b1;
                        busy       <= 1'b0;
                        op_count   <= op_count + 8'd1;
                    end
                end
                S_ERR: begin
                    // err was raised on entry, so the count runs ERR_CYCLES-1 .. 0.
                    if (r_err_cnt == '0) begin
                        r_state <= S_IDLE;
                        err     <= 1'b0;
                        busy    <= 1'b0;
                    end else begin
                        r_err_cnt <= r_err_cnt - 1'b1;
                    end
                end
                default: begin
                    r_state   <= S_IDLE;
                    req_valid <= 1'b0;
                    err       <= 1'b0;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule
